// File: rtl/ebr_pkg.sv
// Shared types for the block-RAM frame reader: FSM states and
// the skid FIFO entry carrying a byte plus its end-of-frame flag.
package ebr_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/ebr_frame_reader_stream_fifo.sv
// Small synchronous FIFO used as the output skid buffer.
// Combinational head read; push and pop may coincide, even when full.
module stream_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rp_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (do_push) wp_d = wp_q + PW'(1);
        if (do_pop)  rp_d = rp_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; the head is only consumed when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= wdata;
    end

endmodule

// File: rtl/ebr_frame_reader.sv
// Burst reader for the EBR frame buffer: issues credit-limited RAM reads
// and replays the returned bytes as a valid/ready stream with last.
import ebr_pkg::*;

module ebr_frame_reader #(
    parameter int DATA_WIDTH = DW,
    parameter int SIZE       = 32,
    parameter int SIZE_WIDTH = $clog2(SIZE),
    parameter int LEN_WIDTH  = SIZE_WIDTH + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [SIZE_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [SIZE_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  infl_q;
    logic                  last_q;

    logic                  issue, issue_last;
    logic                  pop, empty, full;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credit;
    fifo_entry_t           wentry, head;

    // Credit counts the read still in flight so a push always has room.
    assign credit     = {1'b0, fifo_count} + {{CW{1'b0}}, infl_q};
    assign issue      = (state_q == READ) && (rem_q != '0)
                     && (credit < (CW+1)'(FIFO_DEPTH));
    assign issue_last = issue && (rem_q == LEN_WIDTH'(1));
    assign pop        = !empty && m_ready;
    assign wentry     = '{last: last_q, data: rd_data};

    stream_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (infl_q),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            infl_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            infl_q  <= issue;
            last_q  <= issue_last;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d  = base_addr;
                        rem_d   = length;
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_q + SIZE_WIDTH'(1);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (issue_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!infl_q && (empty || (fifo_count == CW'(1) && pop)))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        rd_en   = issue;
        rd_addr = addr_q;
        m_valid = !empty;
        m_data  = m_valid ? head.data : '0;
        m_last  = m_valid && head.last;
    end

    assert property (@(posedge clk) disable iff (rst)
        !(infl_q && full && !pop));

endmodule
